scaled_frame_printer: RTL and testbench



---
 rtl/scaled_frame_printer.sv | 198 +++++++++++++++++++
 tb/tb_scaled_frame_printer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/scaled_frame_printer.sv
// scaled_frame_printer: places a SCALE x SCALE replicated framebuffer image
// in the VGA active area, with optional border and grayscale/RGB332 decode.
module scaled_frame_printer #(
    parameter int          X_START     = 170,
    parameter int          Y_START     = 90,
    parameter int          IMG_W       = 300,
    parameter int          IMG_H       = 300,
    parameter int          SCALE       = 1,
    parameter int          ADDR_W      = 17,
    parameter int          BASE_ADDR   = 324,
    parameter int          MEM_LATENCY = 1,
    parameter int          BORDER_W    = 0,
    parameter logic [23:0] BORDER_RGB  = 24'hFFFFFF
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              color_mode,
    input  logic [7:0]        color,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              hsync_out,
    output logic              vsync_out
);

    localparam int X_END = X_START + IMG_W * SCALE;
    localparam int Y_END = Y_START + IMG_H * SCALE;
    localparam int DEPTH = MEM_LATENCY + 1;
    localparam int CNT_W = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCALE - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = (SCALE > 1) ? CNT_W'(1) : '0;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    typedef struct packed {
        logic video_on;
        logic in_frame;
        logic in_border;
        logic mode;
        logic hsync;
        logic vsync;
    } tag_t;

    logic signed [31:0] px, py;
    logic in_frame, in_win, in_border;
    logic frame_start, line_first, line_last, track;

    logic [ADDR_W-1:0] address_q, address_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] cur_base;
    logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
    logic [CNT_W-1:0]  row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]  cur_row;
    logic              armed_q, armed_d;

    tag_t [DEPTH-1:0] tag_q, tag_d;
    tag_t             tag_in, tag_out;

    logic [7:0] red_q, red_d;
    logic [7:0] green_q, green_d;
    logic [7:0] blue_q, blue_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    assign px = {22'd0, pixel_x};
    assign py = {22'd0, pixel_y};

    // Window decode for the current raster position
    always_comb begin
        in_frame    = (px >= X_START) && (px < X_END) &&
                      (py >= Y_START) && (py < Y_END);
        in_win      = (px >= X_START - BORDER_W) && (px < X_END + BORDER_W) &&
                      (py >= Y_START - BORDER_W) && (py < Y_END + BORDER_W);
        in_border   = in_win && !in_frame;
        frame_start = (px == X_START) && (py == Y_START);
        line_first  = (px == X_START);
        line_last   = (px == X_END - 1);
    end

    // Incremental address walk; frame origin reloads everything
    always_comb begin
        address_d   = address_q;
        line_base_d = line_base_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        armed_d     = armed_q | frame_start;
        track       = in_frame && armed_d;
        cur_base    = frame_start ? BASE : line_base_q;
        cur_row     = frame_start ? '0 : row_cnt_q;
        if (frame_start) begin
            line_base_d = BASE;
            row_cnt_d   = '0;
        end
        if (track) begin
            if (line_first) begin
                address_d = cur_base;
                col_cnt_d = CNT_ONE;
            end else if (col_cnt_q == '0) begin
                address_d = address_q + ADDR_W'(1);
                col_cnt_d = CNT_ONE;
            end else if (col_cnt_q == CNT_LAST) begin
                col_cnt_d = '0;
            end else begin
                col_cnt_d = col_cnt_q + CNT_W'(1);
            end
            if (line_last) begin
                if (cur_row == CNT_LAST) begin
                    line_base_d = cur_base + ROW_STEP;
                    row_cnt_d   = '0;
                end else begin
                    line_base_d = cur_base;
                    row_cnt_d   = cur_row + CNT_W'(1);
                end
            end
        end
    end

    // Pixel tags ride alongside the RAM read latency
    always_comb begin
        tag_in           = '0;
        tag_in.video_on  = video_on;
        tag_in.in_frame  = track;
        tag_in.in_border = in_border;
        tag_in.mode      = color_mode;
        tag_in.hsync     = hsync_in;
        tag_in.vsync     = vsync_in;
        tag_d            = {tag_q[DEPTH-2:0], tag_in};
        tag_out          = tag_q[DEPTH-1];
    end

    // Final colour select: blank, image, border, background
    always_comb begin
        red_d   = 8'd0;
        green_d = 8'd0;
        blue_d  = 8'd0;
        hsync_d = tag_out.hsync;
        vsync_d = tag_out.vsync;
        if (!tag_out.video_on) begin
            red_d = 8'd0;
        end else if (tag_out.in_frame && !tag_out.mode) begin
            red_d   = color;
            green_d = color;
            blue_d  = color;
        end else if (tag_out.in_frame) begin
            red_d   = {color[7:5], color[7:5], color[7:6]};
            green_d = {color[4:2], color[4:2], color[4:3]};
            blue_d  = {4{color[1:0]}};
        end else if (tag_out.in_border) begin
            red_d   = BORDER_RGB[23:16];
            green_d = BORDER_RGB[15:8];
            blue_d  = BORDER_RGB[7:0];
        end
    end

    // State registers
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            address_q   <= BASE;
            line_base_q <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            armed_q     <= 1'b0;
            tag_q       <= '0;
            red_q       <= 8'd0;
            green_q     <= 8'd0;
            blue_q      <= 8'd0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            address_q   <= address_d;
            line_base_q <= line_base_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            armed_q     <= armed_d;
            tag_q       <= tag_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
        end
    end

    assign address   = address_q;
    assign red       = red_q;
    assign green     = green_q;
    assign blue      = blue_q;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;

endmodule

// File: tb/tb_scaled_frame_printer.sv
// tb_scaled_frame_printer: two configurations driven by one random raster,
// compared against an arithmetic per-pixel reference model.
module tb_scaled_frame_printer;

    localparam int H_TOT = 24;
    localparam int V_TOT = 16;
    localparam int H_ACT = 20;
    localparam int V_ACT = 14;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int NFRM  = 6;
    localparam int RST_AT = 2 * FRAME + 5 * H_TOT + 7;

    typedef struct {
        int          xs, ys, w, h, s, base, lat, bw;
        logic [23:0] brgb;
    } cfg_t;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       vo, hs, vs, md;
    logic [9:0] px, py;

    logic [16:0] addr_o [2];
    logic [7:0]  r_o [2];
    logic [7:0]  g_o [2];
    logic [7:0]  b_o [2];
    logic        hs_o [2];
    logic        vs_o [2];

    logic [7:0] col_a = 8'd0;
    logic [7:0] cp_b [3] = '{8'd0, 8'd0, 8'd0};

    cfg_t cfg [2];
    rec_t hist [2][8];
    int   nedge [2];
    int   ea [2];
    bit   armed [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    scaled_frame_printer #(
        .X_START(4), .Y_START(3), .IMG_W(10), .IMG_H(6), .SCALE(1),
        .ADDR_W(17), .BASE_ADDR(324), .MEM_LATENCY(1), .BORDER_W(0),
        .BORDER_RGB(24'hFFFFFF)
    ) dut_a (
        .vga_clk(clk), .rst(rst), .video_on(vo), .hsync_in(hs),
        .vsync_in(vs), .pixel_x(px), .pixel_y(py), .color_mode(md),
        .color(col_a), .address(addr_o[0]), .red(r_o[0]),
        .green(g_o[0]), .blue(b_o[0]), .hsync_out(hs_o[0]),
        .vsync_out(vs_o[0])
    );

    scaled_frame_printer #(
        .X_START(5), .Y_START(4), .IMG_W(5), .IMG_H(4), .SCALE(2),
        .ADDR_W(17), .BASE_ADDR(100), .MEM_LATENCY(3), .BORDER_W(2),
        .BORDER_RGB(24'h12AB34)
    ) dut_b (
        .vga_clk(clk), .rst(rst), .video_on(vo), .hsync_in(hs),
        .vsync_in(vs), .pixel_x(px), .pixel_y(py), .color_mode(md),
        .color(cp_b[2]), .address(addr_o[1]), .red(r_o[1]),
        .green(g_o[1]), .blue(b_o[1]), .hsync_out(hs_o[1]),
        .vsync_out(vs_o[1])
    );

    // framebuffer stand-in: data = low byte of address, fixed read latency
    always @(posedge clk) begin
        col_a   <= addr_o[0][7:0];
        cp_b[0] <= addr_o[1][7:0];
        cp_b[1] <= cp_b[0];
        cp_b[2] <= cp_b[1];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] rgb332(input int c);
        int r3, g3, b2;
        int rr, gg, bb;
        r3 = c / 32;
        g3 = (c / 4) % 8;
        b2 = c % 4;
        rr = r3 * 32 + r3 * 4 + r3 / 2;
        gg = g3 * 32 + g3 * 4 + g3 / 2;
        bb = b2 * 85;
        return {8'(rr), 8'(gg), 8'(bb)};
    endfunction

    task automatic model_reset(input int d);
        armed[d] = 1'b0;
        ea[d]    = cfg[d].base;
        nedge[d] = 0;
    endtask

    task automatic model_edge(input int d);
        int   x, y, fx, fy, cv;
        bit   inf, inb;
        rec_t r;
        x  = int'(px);
        y  = int'(py);
        fx = cfg[d].xs + cfg[d].w * cfg[d].s;
        fy = cfg[d].ys + cfg[d].h * cfg[d].s;
        if (rst) begin
            model_reset(d);
        end else begin
            if (x == cfg[d].xs && y == cfg[d].ys) armed[d] = 1'b1;
            inf = x >= cfg[d].xs && x < fx && y >= cfg[d].ys && y < fy;
            inb = !inf &&
                  x >= cfg[d].xs - cfg[d].bw && x < fx + cfg[d].bw &&
                  y >= cfg[d].ys - cfg[d].bw && y < fy + cfg[d].bw;
            if (inf && armed[d])
                ea[d] = cfg[d].base +
                        ((y - cfg[d].ys) / cfg[d].s) * cfg[d].w +
                        (x - cfg[d].xs) / cfg[d].s;
            cv = ea[d] % 256;
            r = '0;
            if (!vo) r.rgb = 24'h0;
            else if (inf && armed[d]) r.rgb = md ? rgb332(cv) : {3{8'(cv)}};
            else if (inb) r.rgb = cfg[d].brgb;
            r.hs = hs;
            r.vs = vs;
            hist[d][nedge[d] % 8] = r;
            nedge[d]++;
        end
    endtask

    task automatic compare(input int d);
        rec_t  e;
        string p;
        p = (d == 0) ? "A" : "B";
        e = '0;
        if (nedge[d] >= cfg[d].lat + 2)
            e = hist[d][(nedge[d] - cfg[d].lat - 2) % 8];
        chk({p, ".addr"}, 32'(addr_o[d]), ea[d]);
        chk({p, ".rgb"}, 32'({r_o[d], g_o[d], b_o[d]}), 32'(e.rgb));
        chk({p, ".hs"}, 32'(hs_o[d]), 32'(e.hs));
        chk({p, ".vs"}, 32'(vs_o[d]), 32'(e.vs));
    endtask

    initial begin
        cfg[0] = '{xs: 4, ys: 3, w: 10, h: 6, s: 1, base: 324, lat: 1,
                   bw: 0, brgb: 24'hFFFFFF};
        cfg[1] = '{xs: 5, ys: 4, w: 5, h: 4, s: 2, base: 100, lat: 3,
                   bw: 2, brgb: 24'h12AB34};
        rst = 1'b1;
        vo  = 1'b0;
        hs  = 1'b0;
        vs  = 1'b0;
        md  = 1'b0;
        px  = 10'd0;
        py  = 10'd0;
        model_reset(0);
        model_reset(1);
        repeat (3) @(negedge clk);
        compare(0);
        compare(1);
        for (int cyc = 0; cyc < NFRM * FRAME; cyc++) begin
            int x, y;
            x   = cyc % H_TOT;
            y   = (cyc / H_TOT) % V_TOT;
            rst = (cyc >= RST_AT) && (cyc < RST_AT + 3);
            px  = 10'(x);
            py  = 10'(y);
            vo  = (x < H_ACT) && (y < V_ACT) && ($urandom_range(7) != 0);
            hs  = 1'($urandom_range(1));
            vs  = ($urandom_range(3) == 0);
            md  = 1'($urandom_range(1));
            @(posedge clk);
            model_edge(0);
            model_edge(1);
            @(negedge clk);
            compare(0);
            compare(1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
